// File: rtl/axis_matvec_acc_if.sv
// AXI-Stream style bundle for the matrix-vector accumulator: the {k, x} input
// stream and the y result stream. The slave modport is the accumulator's view;
// the master modport is the surrounding environment's view.
interface axis_matvec_acc_if #(
   parameter int R         = 8,
   parameter int C         = 8,
   parameter int W_X       = 8,
   parameter int W_K       = 8,
   parameter int MAX_BEATS = 16
);
   localparam int W_Y = W_X + W_K + $clog2(C * MAX_BEATS);

   logic                     s_axis_kx_tready;
   logic                     s_axis_kx_tvalid;
   logic [R*C*W_K+C*W_X-1:0] s_axis_kx_tdata;
   logic                     s_axis_kx_tlast;

   logic                     m_axis_y_tready;
   logic                     m_axis_y_tvalid;
   logic [R*W_Y-1:0]         m_axis_y_tdata;
   logic                     m_axis_y_tuser;

   modport slave (
      output s_axis_kx_tready,
      input  s_axis_kx_tvalid,
      input  s_axis_kx_tdata,
      input  s_axis_kx_tlast,
      input  m_axis_y_tready,
      output m_axis_y_tvalid,
      output m_axis_y_tdata,
      output m_axis_y_tuser
   );

   modport master (
      input  s_axis_kx_tready,
      output s_axis_kx_tvalid,
      output s_axis_kx_tdata,
      output s_axis_kx_tlast,
      output m_axis_y_tready,
      input  m_axis_y_tvalid,
      input  m_axis_y_tdata,
      input  m_axis_y_tuser
   );
endinterface

// File: rtl/axis_matvec_acc.sv
// Streaming matrix-vector accumulator. Each input beat carries an R x C tile
// of K and a C-element slice of x; the tile products are summed per row and
// accumulated over all beats of a packet. The packet total is presented on the
// y stream one cycle after the tlast handshake, with tuser flagging packets
// longer than MAX_BEATS beats. Arithmetic wraps modulo 2^W_Y.
module axis_matvec_acc #(
   parameter int R         = 8,
   parameter int C         = 8,
   parameter int W_X       = 8,
   parameter int W_K       = 8,
   parameter int MAX_BEATS = 16,
   parameter int SIGNED    = 1
) (
   input  logic                clk,
   input  logic                rstn,
   axis_matvec_acc_if.slave    bus
);
   localparam int W_Y   = W_X + W_K + $clog2(C * MAX_BEATS);
   localparam int W_CNT = $clog2(MAX_BEATS + 2);

   typedef enum logic {
      ACC_IDLE,
      ACC_RUN
   } acc_state_e;

   acc_state_e                state_q, state_d;
   logic [R-1:0][W_Y-1:0]     tile_sum;
   logic [R-1:0][W_Y-1:0]     sum_d;
   logic [R-1:0][W_Y-1:0]     acc_q;
   logic [R-1:0][W_Y-1:0]     y_q;
   logic                      y_vld_q;
   logic                      y_user_q;
   logic [W_CNT-1:0]          cnt_q;
   logic [W_CNT-1:0]          cnt_inc;
   logic                      over;
   logic                      accept;
   logic [W_Y-1:0]            x_e;
   logic [W_Y-1:0]            k_e;

   function automatic logic [W_Y-1:0] ext_x(input logic [W_X-1:0] v);
      return {{(W_Y-W_X){(SIGNED != 0) && v[W_X-1]}}, v};
   endfunction

   function automatic logic [W_Y-1:0] ext_k(input logic [W_K-1:0] v);
      return {{(W_Y-W_K){(SIGNED != 0) && v[W_K-1]}}, v};
   endfunction

   // Any beat, including non-tlast ones, waits until the output slot can accept a result.
   assign bus.s_axis_kx_tready = !y_vld_q || bus.m_axis_y_tready;
   assign accept               = bus.s_axis_kx_tvalid && bus.s_axis_kx_tready;

   assign bus.m_axis_y_tvalid  = y_vld_q;
   assign bus.m_axis_y_tdata   = y_q;
   assign bus.m_axis_y_tuser   = y_user_q;

   // Per-row tile sum of the current beat plus the running packet sum it produces.
   // Operands are extended to W_Y before multiplying, so the low W_Y bits of the
   // product are already the wrapped signed/unsigned result.
   always_comb begin
      tile_sum = '0;
      sum_d    = '0;
      x_e      = '0;
      k_e      = '0;
      for (int unsigned r = 0; r < R; r++) begin
         for (int unsigned c = 0; c < C; c++) begin
            x_e = ext_x(bus.s_axis_kx_tdata[c*W_X +: W_X]);
            k_e = ext_k(bus.s_axis_kx_tdata[C*W_X + (r*C+c)*W_K +: W_K]);
            tile_sum[r] = tile_sum[r] + x_e * k_e;
         end
         sum_d[r] = ((state_q == ACC_RUN) ? acc_q[r] : '0) + tile_sum[r];
      end
   end

   // Beat count for this packet, saturating one past the overflow threshold.
   always_comb begin
      cnt_inc = (cnt_q == W_CNT'(MAX_BEATS + 1)) ? cnt_q : cnt_q + 1'b1;
      over    = cnt_inc > W_CNT'(MAX_BEATS);
   end

   // Packet state: RUN once a non-final beat is taken, back to IDLE on tlast.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = bus.s_axis_kx_tlast ? ACC_IDLE : ACC_RUN;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ACC_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Running accumulator and beat counter, updated on every accepted beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         acc_q <= sum_d;
         cnt_q <= bus.s_axis_kx_tlast ? '0 : cnt_inc;
      end
   end

   // Output register: a tlast load takes priority, so a same-cycle drain and
   // reload keeps tvalid high with no bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         y_vld_q  <= 1'b0;
         y_q      <= '0;
         y_user_q <= 1'b0;
      end else if (accept && bus.s_axis_kx_tlast) begin
         y_vld_q  <= 1'b1;
         y_q      <= sum_d;
         y_user_q <= over;
      end else if (bus.m_axis_y_tready) begin
         y_vld_q  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axis_matvec_acc.sv
// Directed and random checks for axis_matvec_acc. A signed and an unsigned
// instance receive identical input streams so both arithmetic modes are
// compared against hand-computed values and a behavioural row-sum model.
module tb_axis_matvec_acc;
   localparam int R   = 8;
   localparam int C   = 8;
   localparam int W_X = 8;
   localparam int W_K = 8;
   localparam int MB  = 16;
   localparam int W_Y = 23;
   localparam int DW  = R*C*W_K + C*W_X;
   localparam int YW  = R*W_Y;

   typedef struct {
      logic [7:0]  k;
      logic [7:0]  x;
      int          nb;
      logic [22:0] exp_s;
      logic [22:0] exp_u;
      logic        exp_user;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;
   int   total = 0;
   int   bad   = 0;
   bit   rdy_rand  = 1'b0;
   bit   rdy_force = 1'b1;

   logic [YW-1:0] got_s[$];
   logic [YW-1:0] got_u[$];
   logic          got_user[$];
   logic [YW-1:0] exp_s_q[$];
   logic [YW-1:0] exp_u_q[$];

   always #5 clk = ~clk;

   axis_matvec_acc_if #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_BEATS(MB)) bs ();
   axis_matvec_acc_if #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_BEATS(MB)) bu ();

   assign bu.s_axis_kx_tvalid = bs.s_axis_kx_tvalid;
   assign bu.s_axis_kx_tdata  = bs.s_axis_kx_tdata;
   assign bu.s_axis_kx_tlast  = bs.s_axis_kx_tlast;
   assign bu.m_axis_y_tready  = bs.m_axis_y_tready;

   axis_matvec_acc #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_BEATS(MB), .SIGNED(1)) dut_s (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bs)
   );

   axis_matvec_acc #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .MAX_BEATS(MB), .SIGNED(0)) dut_u (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bu)
   );

   // Record every completed output handshake of both instances.
   always @(negedge clk) begin
      if (rstn && bs.m_axis_y_tvalid && bs.m_axis_y_tready) begin
         got_s.push_back(bs.m_axis_y_tdata);
         got_u.push_back(bu.m_axis_y_tdata);
         got_user.push_back(bs.m_axis_y_tuser);
      end
   end

   // Output-side ready, updated just after each rising edge.
   initial begin
      bs.m_axis_y_tready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bs.m_axis_y_tready = rdy_rand ? ($urandom_range(0, 99) < 10) : rdy_force;
      end
   end

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [YW-1:0] rep(input logic [22:0] v);
      logic [YW-1:0] o;
      for (int r = 0; r < R; r++) o[r*W_Y +: W_Y] = v;
      return o;
   endfunction

   function automatic logic [DW-1:0] mk_data(input logic [7:0] k, input logic [7:0] x);
      logic [DW-1:0] d;
      for (int c = 0; c < C; c++) d[c*W_X +: W_X] = x;
      for (int i = 0; i < R*C; i++) d[C*W_X + i*W_K +: W_K] = k;
      return d;
   endfunction

   function automatic int row_sum(input logic [DW-1:0] d, input int r, input bit sgn);
      int s;
      s = 0;
      for (int c = 0; c < C; c++) begin
         logic [7:0] kk;
         logic [7:0] xx;
         kk = d[C*W_X + (r*C+c)*W_K +: W_K];
         xx = d[c*W_X +: W_X];
         if (sgn) s += int'($signed(kk)) * int'($signed(xx));
         else     s += int'(kk) * int'(xx);
      end
      return s;
   endfunction

   // Hold the current beat until the handshake edge has passed.
   task automatic wait_hs();
      bit hs;
      int n;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 1000) begin
         @(negedge clk);
         hs = bs.s_axis_kx_tready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!hs) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout: got=no_tready want=tready");
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input bit last, input int pv);
      int n;
      n = 0;
      bs.s_axis_kx_tvalid = 1'b0;
      while ($urandom_range(0, 99) >= pv && n < 200) begin
         cyc(1);
         n++;
      end
      bs.s_axis_kx_tdata  = d;
      bs.s_axis_kx_tlast  = last;
      bs.s_axis_kx_tvalid = 1'b1;
      wait_hs();
      bs.s_axis_kx_tvalid = 1'b0;
   endtask

   task automatic wait_outputs(input int n, input int budget);
      int k;
      k = 0;
      while (got_s.size() < n && k < budget) begin
         cyc(1);
         k++;
      end
      if (got_s.size() < n) begin
         total++;
         bad++;
         $display("FAIL output_timeout: got=%0d want=%0d", got_s.size(), n);
      end
   endtask

   task automatic clear_got();
      got_s.delete();
      got_u.delete();
      got_user.delete();
   endtask

   initial begin
      vec_t          tbl[8];
      logic [DW-1:0] d;
      logic [YW-1:0] es;
      logic [YW-1:0] eu;
      int            acc_s[R];
      int            acc_u[R];
      int            nb;
      int            nchk;

      tbl[0] = '{8'h01, 8'h02,  1, 23'd16,      23'd16,     1'b0};
      tbl[1] = '{8'hFF, 8'h7F,  1, 23'h7FFC08,  23'h03F408, 1'b0};
      tbl[2] = '{8'hFF, 8'hFF,  1, 23'd8,       23'd520200, 1'b0};
      tbl[3] = '{8'h01, 8'h01,  3, 23'd24,      23'd24,     1'b0};
      tbl[4] = '{8'h01, 8'h01, 17, 23'd136,     23'd136,    1'b1};
      tbl[5] = '{8'h01, 8'h01, 16, 23'd128,     23'd128,    1'b0};
      tbl[6] = '{8'hFF, 8'hFF, 17, 23'd136,     23'h06F088, 1'b1};
      tbl[7] = '{8'h80, 8'h7F,  2, 23'h7C0800,  23'h03F800, 1'b0};

      bs.s_axis_kx_tvalid = 1'b0;
      bs.s_axis_kx_tlast  = 1'b0;
      bs.s_axis_kx_tdata  = '0;
      rstn = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bs.m_axis_y_tvalid, 0);
      check("rst_data_s", bs.m_axis_y_tdata, 0);
      check("rst_data_u", bu.m_axis_y_tdata, 0);
      check("rst_user", bs.m_axis_y_tuser, 0);
      check("rst_ready", bs.s_axis_kx_tready, 1);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // One-beat packet and its one-cycle latency.
      bs.s_axis_kx_tdata  = mk_data(8'h01, 8'h02);
      bs.s_axis_kx_tlast  = 1'b1;
      bs.s_axis_kx_tvalid = 1'b1;
      @(negedge clk);
      check("lat_pre_valid", bs.m_axis_y_tvalid, 0);
      check("lat_ready", bs.s_axis_kx_tready, 1);
      @(posedge clk);
      #1;
      bs.s_axis_kx_tvalid = 1'b0;
      check("lat_valid", bs.m_axis_y_tvalid, 1);
      check("lat_data", bs.m_axis_y_tdata, rep(23'd16));
      check("lat_user", bs.m_axis_y_tuser, 0);
      wait_outputs(1, 20);
      clear_got();
      cyc(2);

      // Uniform-data packets with random valid gaps.
      for (int i = 0; i < 8; i++) begin
         for (int b = 0; b < tbl[i].nb; b++) begin
            send_beat(mk_data(tbl[i].k, tbl[i].x), b == tbl[i].nb - 1, 50);
         end
         wait_outputs(1, 50);
         cyc(3);
         check($sformatf("tbl%0d_count", i), got_s.size(), 1);
         if (got_s.size() > 0) begin
            check($sformatf("tbl%0d_ys", i), got_s[0], rep(tbl[i].exp_s));
            check($sformatf("tbl%0d_yu", i), got_u[0], rep(tbl[i].exp_u));
            check($sformatf("tbl%0d_user", i), got_user[0], tbl[i].exp_user);
         end
         clear_got();
      end

      // Output back-pressure, then drain and reload on the same edge.
      rdy_force = 1'b0;
      cyc(1);
      send_beat(mk_data(8'h01, 8'h01), 1'b1, 100);
      bs.s_axis_kx_tdata  = mk_data(8'h01, 8'h02);
      bs.s_axis_kx_tlast  = 1'b1;
      bs.s_axis_kx_tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("stall%0d_ready", i), bs.s_axis_kx_tready, 0);
         check($sformatf("stall%0d_valid", i), bs.m_axis_y_tvalid, 1);
         check($sformatf("stall%0d_data", i), bs.m_axis_y_tdata, rep(23'd8));
      end
      rdy_force = 1'b1;
      wait_hs();
      bs.s_axis_kx_tvalid = 1'b0;
      check("nobubble_valid", bs.m_axis_y_tvalid, 1);
      check("nobubble_data", bs.m_axis_y_tdata, rep(23'd16));
      wait_outputs(2, 20);
      if (got_s.size() >= 2) begin
         check("stall_first", got_s[0], rep(23'd8));
         check("stall_second", got_s[1], rep(23'd16));
      end
      clear_got();

      // Reset in the middle of a packet discards the partial sum.
      send_beat(mk_data(8'h01, 8'h01), 1'b0, 100);
      send_beat(mk_data(8'h01, 8'h01), 1'b0, 100);
      rstn = 1'b0;
      cyc(2);
      @(negedge clk);
      check("midrst_valid", bs.m_axis_y_tvalid, 0);
      check("midrst_ready", bs.s_axis_kx_tready, 1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      send_beat(mk_data(8'h01, 8'h03), 1'b1, 100);
      wait_outputs(1, 20);
      cyc(3);
      check("midrst_count", got_s.size(), 1);
      if (got_s.size() > 0) begin
         check("midrst_ys", got_s[0], rep(23'd24));
         check("midrst_yu", got_u[0], rep(23'd24));
      end
      clear_got();

      // Reset while a result is waiting drops it.
      rdy_force = 1'b0;
      cyc(1);
      send_beat(mk_data(8'h01, 8'h01), 1'b1, 100);
      cyc(1);
      check("pend_valid", bs.m_axis_y_tvalid, 1);
      rstn = 1'b0;
      #1;
      check("pend_rst_valid", bs.m_axis_y_tvalid, 0);
      check("pend_rst_data", bs.m_axis_y_tdata, 0);
      cyc(2);
      rstn = 1'b1;
      rdy_force = 1'b1;
      cyc(5);
      check("pend_dropped", got_s.size(), 0);
      clear_got();

      // Random regression against the row-sum model.
      rdy_rand = 1'b1;
      for (int p = 0; p < 500; p++) begin
         nb = $urandom_range(1, MB);
         for (int r = 0; r < R; r++) begin
            acc_s[r] = 0;
            acc_u[r] = 0;
         end
         for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
            for (int r = 0; r < R; r++) begin
               acc_s[r] += row_sum(d, r, 1'b1);
               acc_u[r] += row_sum(d, r, 1'b0);
            end
            send_beat(d, b == nb - 1, 10);
         end
         for (int r = 0; r < R; r++) begin
            es[r*W_Y +: W_Y] = acc_s[r][W_Y-1:0];
            eu[r*W_Y +: W_Y] = acc_u[r][W_Y-1:0];
         end
         exp_s_q.push_back(es);
         exp_u_q.push_back(eu);
      end
      wait_outputs(500, 20000);
      rdy_rand = 1'b0;
      nchk = (got_s.size() < 500) ? got_s.size() : 500;
      for (int i = 0; i < nchk; i++) begin
         check($sformatf("rnd%0d_ys", i), got_s[i], exp_s_q[i]);
         check($sformatf("rnd%0d_yu", i), got_u[i], exp_u_q[i]);
         check($sformatf("rnd%0d_user", i), got_user[i], 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
